// File: rtl/hpm_counter_bank.sv
// Bank of RISC-V mhpmcounter/mhpmevent CSRs plus mcountinhibit, one lane per counter.
// Optional overflow flags and interrupt are built when HPM_OVERFLOW_IRQ_EN is defined.

module hpm_counter #(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  inhibit,
    input  logic                  wr_lo,
    input  logic                  wr_hi,
    input  logic                  wr_evt,
    input  logic [31:0]           w_data,
    output logic [31:0]           rd_lo,
    output logic [31:0]           rd_hi,
    output logic [31:0]           rd_evt
);
    logic [COUNTER_WIDTH-1:0] count_q, count_nxt, hi_merge;
    logic [7:0]               sel_q;
    logic                     evt_hit, inc, of_bit;

    // Selects 0 and values above NUM_EVENTS match no iteration and never count.
    always_comb begin
        evt_hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++)
            if (sel_q == 8'(k + 1)) evt_hit = event_i[k];
    end

    assign inc = evt_hit && !inhibit;

    generate
        if (COUNTER_WIDTH > 32) begin : g_hi
            assign hi_merge = {w_data[COUNTER_WIDTH-33:0], count_q[31:0]};
            assign rd_hi    = 32'(count_q[COUNTER_WIDTH-1:32]);
        end else begin : g_no_hi
            assign hi_merge = count_q;
            assign rd_hi    = 32'd0;
        end
    endgenerate

    // Any write to either half suppresses this cycle's increment.
    always_comb begin
        count_nxt = count_q;
        if (wr_lo)      count_nxt[31:0] = w_data;
        else if (wr_hi) count_nxt = hi_merge;
        else if (inc)   count_nxt = count_q + COUNTER_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            sel_q   <= '0;
        end else begin
            count_q <= count_nxt;
            if (wr_evt) sel_q <= w_data[7:0];
        end
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic of_q, wrap;
    assign wrap = inc && (&count_q) && !wr_lo && !wr_hi;

    // A wrap in the same cycle as a software clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    of_q <= 1'b0;
        else if (wrap)   of_q <= 1'b1;
        else if (wr_evt) of_q <= w_data[31];
    end
    assign of_bit = of_q;
`else
    assign of_bit = 1'b0;
`endif

    assign rd_lo  = count_q[31:0];
    assign rd_evt = {of_bit, 23'd0, sel_q};
endmodule

module hpm_counter_bank #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_w_data,
    input  logic                  csr_w_en,
    output logic [31:0]           csr_data_o,
    output logic                  csr_hit_o,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  overflow_irq_o
);
    logic [4:0]                    off, idx;
    logic                          in_range, lo_hit, hi_hit, evt_hit, inh_hit;
    logic [NUM_COUNTERS-1:0]       inh_q;
    logic [NUM_COUNTERS-1:0][31:0] rd_lo, rd_hi, rd_evt;

    // Counter i sits at offset 3+i within each 32-entry CSR group.
    assign off      = csr_addr[4:0];
    assign idx      = off - 5'd3;
    assign in_range = (off >= 5'd3) && (idx < 5'(NUM_COUNTERS));
    assign lo_hit   = (csr_addr[11:5] == 7'h58) && in_range;
    assign hi_hit   = (csr_addr[11:5] == 7'h5C) && in_range;
    assign evt_hit  = (csr_addr[11:5] == 7'h19) && in_range;
    assign inh_hit  = (csr_addr == 12'h320);
    assign csr_hit_o = lo_hit || hi_hit || evt_hit || inh_hit;

    always_comb begin
        csr_data_o = 32'd0;
        if (inh_hit) csr_data_o = 32'(inh_q) << 3;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if (idx == 5'(k)) begin
                if (lo_hit)  csr_data_o = rd_lo[k];
                if (hi_hit)  csr_data_o = rd_hi[k];
                if (evt_hit) csr_data_o = rd_evt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 inh_q <= '0;
        else if (csr_w_en && inh_hit) inh_q <= csr_w_data[3 +: NUM_COUNTERS];
    end

    genvar g;
    generate
        for (g = 0; g < NUM_COUNTERS; g++) begin : g_lane
            hpm_counter #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .NUM_EVENTS    (NUM_EVENTS)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .event_i (event_i),
                .inhibit (inh_q[g]),
                .wr_lo   (csr_w_en && lo_hit && (idx == 5'(g))),
                .wr_hi   (csr_w_en && hi_hit && (idx == 5'(g))),
                .wr_evt  (csr_w_en && evt_hit && (idx == 5'(g))),
                .w_data  (csr_w_data),
                .rd_lo   (rd_lo[g]),
                .rd_hi   (rd_hi[g]),
                .rd_evt  (rd_evt[g])
            );
        end
    endgenerate

`ifdef HPM_OVERFLOW_IRQ_EN
    logic of_any, irq_q;
    always_comb begin
        of_any = 1'b0;
        for (int k = 0; k < NUM_COUNTERS; k++) of_any = of_any | rd_evt[k][31];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= of_any;
    end
    assign overflow_irq_o = irq_q;
`else
    assign overflow_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank (4 counters, 40-bit, 16 events) with a
// queue of expected read values popped as each read settles.

module tb_hpm_counter_bank;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_w_data = '0;
    logic        csr_w_en = 1'b0;
    logic [31:0] csr_data_o;
    logic        csr_hit_o;
    logic [15:0] event_i = '0;
    logic        overflow_irq_o;

`ifdef HPM_OVERFLOW_IRQ_EN
    localparam logic OF_EN = 1'b1;
`else
    localparam logic OF_EN = 1'b0;
`endif

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    logic [31:0] exp_q[$];

    hpm_counter_bank #(
        .NUM_COUNTERS  (4),
        .COUNTER_WIDTH (40),
        .NUM_EVENTS    (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_addr       (csr_addr),
        .csr_w_data     (csr_w_data),
        .csr_w_en       (csr_w_en),
        .csr_data_o     (csr_data_o),
        .csr_hit_o      (csr_hit_o),
        .event_i        (event_i),
        .overflow_irq_o (overflow_irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr   = a;
        csr_w_data = d;
        csr_w_en   = 1'b1;
        @(posedge clk);
        #1;
        csr_w_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        csr_addr = a;
        #1;
        chk(tag, csr_data_o);
    endtask

    task automatic hit(input string tag, input logic [11:0] a, input logic e);
        exp_q.push_back({31'd0, e});
        csr_addr = a;
        #1;
        chk(tag, {31'd0, csr_hit_o});
    endtask

    task automatic irq(input string tag, input logic e);
        exp_q.push_back({31'd0, e});
        chk(tag, {31'd0, overflow_irq_o});
    endtask

    initial begin
        tick();
        rd("rst_init_cnt", 12'hB03, 32'h0);
        irq("rst_init_irq", 1'b0);
        reset_n = 1'b1;

        // Event select: counter 0 on event 2 for ten cycles.
        csr_wr(12'h323, 32'd2);
        event_i = 16'h0002;
        repeat (10) tick();
        event_i = '0;
        rd("sel_cnt0", 12'hB03, 32'd10);
        rd("sel_cnt0_hi", 12'hB83, 32'd0);
        rd("sel_cnt1", 12'hB04, 32'd0);
        rd("sel_evt3", 12'h323, 32'd2);

        // Wrap of a 40-bit counter; the high half keeps only 8 bits.
        csr_wr(12'hB03, 32'hFFFF_FFFF);
        csr_wr(12'hB83, 32'hFFFF_FFFF);
        rd("hi_trunc", 12'hB83, 32'h0000_00FF);
        rd("lo_full", 12'hB03, 32'hFFFF_FFFF);
        csr_wr(12'h323, 32'd1);
        event_i = 16'h0001;
        tick();
        event_i = '0;
        rd("wrap_lo", 12'hB03, 32'h0);
        rd("wrap_hi", 12'hB83, 32'h0);
        rd("wrap_of", 12'h323, OF_EN ? 32'h8000_0001 : 32'h0000_0001);
        irq("irq_lat0", 1'b0);
        tick();
        irq("irq_set", OF_EN);
        csr_wr(12'h323, 32'd1);
        irq("irq_hold", OF_EN);
        rd("of_clr", 12'h323, 32'd1);
        tick();
        irq("irq_clr", 1'b0);

        // Inhibit while event 1 is held high.
        event_i = 16'h0001;
        csr_wr(12'hB03, 32'd0);
        rd("inh_start", 12'hB03, 32'd0);
        tick();
        tick();
        csr_wr(12'h320, 32'h8);
        rd("inh_edge", 12'hB03, 32'd3);
        rd("inh_rd", 12'h320, 32'h8);
        repeat (3) tick();
        rd("inh_hold", 12'hB03, 32'd3);
        csr_wr(12'h320, 32'h0);
        rd("inh_rel", 12'hB03, 32'd3);
        tick();
        rd("resume1", 12'hB03, 32'd4);
        tick();
        rd("resume2", 12'hB03, 32'd5);

        // Write beats a same-cycle increment, on either half.
        csr_wr(12'hB03, 32'h100);
        rd("wr_vs_inc", 12'hB03, 32'h100);
        csr_wr(12'hB83, 32'h12);
        rd("hi_wr_lo", 12'hB03, 32'h100);
        rd("hi_wr_hi", 12'hB83, 32'h12);
        event_i = '0;

        csr_wr(12'h320, 32'hFFFF_FFFF);
        rd("inh_mask", 12'h320, 32'h78);
        csr_wr(12'h320, 32'h0);

        // Out-of-range select is stored but never counts.
        csr_wr(12'h324, 32'd200);
        event_i = '1;
        repeat (3) tick();
        rd("sel_oor_cnt", 12'hB04, 32'd0);
        rd("sel_oor_rd", 12'h324, 32'd200);

        hit("dec_b07_hit", 12'hB07, 1'b0);
        rd("dec_b07_data", 12'hB07, 32'd0);
        hit("dec_327_hit", 12'h327, 1'b0);
        hit("dec_321_hit", 12'h321, 1'b0);
        hit("dec_b03_hit", 12'hB03, 1'b1);
        hit("dec_b86_hit", 12'hB86, 1'b1);

        // Reset mid-count clears everything before the next edge.
        csr_wr(12'h320, 32'h10);
        tick();
        reset_n = 1'b0;
        rd("rst_cnt_lo", 12'hB03, 32'd0);
        rd("rst_cnt_hi", 12'hB83, 32'd0);
        rd("rst_evt3", 12'h323, 32'd0);
        rd("rst_evt4", 12'h324, 32'd0);
        rd("rst_inh", 12'h320, 32'd0);
        irq("rst_irq", 1'b0);
        event_i = '0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
